// File: rtl/rv32i_dmem_responder.sv
// rv32i_dmem_responder: single-outstanding data-memory responder for an RV32I
// load/store port. Requests are decoded by funct3, answered after LATENCY wait
// cycles on a valid/ready response channel.
//   clock, reset_n        : clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   : request handshake
//   req_we, req_funct3    : store flag and RV32I funct3
//   req_addr, req_wdata   : byte address, store data (low lanes used)
//   rsp_valid/rsp_ready   : response handshake
//   rsp_rdata, rsp_err    : extended load data (0 for stores/errors), error flag
module rv32i_dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = 4;
  localparam bit ZERO_LAT = (LATENCY == 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [31:0]     addr_q, wdata_q;
  logic            ready_d, valid_d, err_d;
  logic [31:0]     rdata_d;

  logic [31:0]     mem [DEPTH_WORDS];

  logic            accept, enter_resp;
  logic            eff_we;
  logic [2:0]      eff_f3;
  logic [31:0]     eff_addr, eff_wdata;
  logic [AW-1:0]   idx;
  logic [4:0]      sh;
  logic [31:0]     word_rd, shifted, ld_data, wmask, wlanes;
  logic            acc_err, out_of_range;

  assign accept     = req_valid && req_ready;
  // Commit happens on the edge that enters RESP.
  assign enter_resp = (ZERO_LAT && state_q == IDLE && accept) ||
                      (state_q == WAIT && cnt_q == CW'(1));

  // With zero latency the commit uses the live request; otherwise the captured one.
  assign eff_we    = (state_q == IDLE) ? req_we     : we_q;
  assign eff_f3    = (state_q == IDLE) ? req_funct3 : f3_q;
  assign eff_addr  = (state_q == IDLE) ? req_addr   : addr_q;
  assign eff_wdata = (state_q == IDLE) ? req_wdata  : wdata_q;

  assign idx          = eff_addr[AW+1:2];
  assign sh           = {eff_addr[1:0], 3'b000};
  assign word_rd      = mem[idx];
  assign shifted      = word_rd >> sh;
  assign out_of_range = (32'(eff_addr[31:2]) >= 32'(DEPTH_WORDS));

  // funct3 decode: load extraction, store lane mask, error detection
  always_comb begin
    acc_err = 1'b0;
    ld_data = '0;
    wmask   = '0;
    wlanes  = '0;
    unique case (eff_f3)
      3'b000: begin
        ld_data = {{24{shifted[7]}}, shifted[7:0]};
        wmask   = 32'h0000_00FF << sh;
        wlanes  = {4{eff_wdata[7:0]}};
      end
      3'b001: begin
        acc_err = eff_addr[0];
        ld_data = {{16{shifted[15]}}, shifted[15:0]};
        wmask   = 32'h0000_FFFF << sh;
        wlanes  = {2{eff_wdata[15:0]}};
      end
      3'b010: begin
        acc_err = |eff_addr[1:0];
        ld_data = word_rd;
        wmask   = 32'hFFFF_FFFF;
        wlanes  = eff_wdata;
      end
      3'b100: begin
        acc_err = eff_we;
        ld_data = {24'h0, shifted[7:0]};
      end
      3'b101: begin
        acc_err = eff_we | eff_addr[0];
        ld_data = {16'h0, shifted[15:0]};
      end
      default: acc_err = 1'b1;
    endcase
    acc_err = acc_err | out_of_range;
  end

  // Word array; contents survive reset
  always_ff @(posedge clock) begin
    if (enter_resp && eff_we && !acc_err)
      mem[idx] <= (word_rd & ~wmask) | (wlanes & wmask);
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = ZERO_LAT ? RESP : WAIT;
      WAIT: if (cnt_q == CW'(1)) state_d = RESP;
      RESP: if (rsp_valid && rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    cnt_d   = cnt_q;
    valid_d = rsp_valid;
    rdata_d = rsp_rdata;
    err_d   = rsp_err;
    ready_d = (state_d == IDLE);
    unique case (state_q)
      IDLE: if (accept) cnt_d = CW'(LATENCY);
      WAIT: cnt_d = cnt_q - CW'(1);
      RESP: if (rsp_valid && rsp_ready) begin
        valid_d = 1'b0;
        rdata_d = '0;
        err_d   = 1'b0;
      end
      default: ;
    endcase
    if (enter_resp) begin
      cnt_d   = '0;
      valid_d = 1'b1;
      err_d   = acc_err;
      rdata_d = (!eff_we && !acc_err) ? ld_data : 32'h0;
    end
  end

  // Registered outputs, counter and captured request
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      f3_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      req_ready <= ready_d;
      rsp_valid <= valid_d;
      rsp_rdata <= rdata_d;
      rsp_err   <= err_d;
      cnt_q     <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

endmodule

// File: tb/tb_rv32i_dmem_responder.sv
// Directed bench for rv32i_dmem_responder: one LATENCY=2 instance driven from a
// vector table plus hand sequences, and one LATENCY=0 instance.
module tb_rv32i_dmem_responder;

  localparam int unsigned DW = 16;

  logic        clock, reset_n;
  logic        req_valid, req_we, rsp_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        sel;

  logic        rr2, rv2, re2, rr0, rv0, re0;
  logic [31:0] rd2, rd0;
  logic        m_ready, m_valid, m_err;
  logic [31:0] m_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  rv32i_dmem_responder #(.DEPTH_WORDS(DW), .LATENCY(2)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid & ~sel), .req_ready(rr2),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv2), .rsp_ready(rsp_ready & ~sel), .rsp_rdata(rd2), .rsp_err(re2));

  rv32i_dmem_responder #(.DEPTH_WORDS(DW), .LATENCY(0)) dut0 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid & sel), .req_ready(rr0),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv0), .rsp_ready(rsp_ready & sel), .rsp_rdata(rd0), .rsp_err(re0));

  assign m_ready = sel ? rr0 : rr2;
  assign m_valid = sel ? rv0 : rv2;
  assign m_rdata = sel ? rd0 : rd2;
  assign m_err   = sel ? re0 : re2;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Full request/response transaction; lat counts edges from acceptance to rsp_valid.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat);
    int guard;
    @(negedge clock);
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    guard = 0;
    while (!m_ready && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    if (!m_ready) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: req_ready stayed %b", m_ready);
    end
    @(posedge clock);
    #1 req_valid = 1'b0;
    lat = 1;
    @(negedge clock);
    while (!m_valid && lat < 40) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
    rd = m_rdata;
    er = m_err;
    rsp_ready = 1'b1;
    @(posedge clock);
    #1 rsp_ready = 1'b0;
  endtask

  vec_t        vt[$];
  logic [31:0] rd;
  logic        er;
  int          lat, guard;

  initial begin
    sel = 1'b0; reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; rsp_ready = 1'b0;
    req_funct3 = '0; req_addr = '0; req_wdata = '0;

    vt.push_back('{1'b1, 3'b010, 32'h20, 32'h0BAD_F00D, 32'h0, 1'b0});
    vt.push_back('{1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0});
    vt.push_back('{1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0});
    vt.push_back('{1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFF_FFDE, 1'b0});
    vt.push_back('{1'b0, 3'b100, 32'h13, 32'h0, 32'h0000_00DE, 1'b0});
    vt.push_back('{1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF_DEAD, 1'b0});
    vt.push_back('{1'b0, 3'b101, 32'h10, 32'h0, 32'h0000_BEEF, 1'b0});
    vt.push_back('{1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFF_FFEF, 1'b0});
    vt.push_back('{1'b1, 3'b000, 32'h11, 32'h0000_00AA, 32'h0, 1'b0});
    vt.push_back('{1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_AAEF, 1'b0});
    vt.push_back('{1'b1, 3'b001, 32'h12, 32'h0000_1234, 32'h0, 1'b0});
    vt.push_back('{1'b0, 3'b010, 32'h10, 32'h0, 32'h1234_AAEF, 1'b0});
    vt.push_back('{1'b0, 3'b010, 32'h02, 32'h0, 32'h0, 1'b1});
    vt.push_back('{1'b1, 3'b001, 32'h11, 32'h0000_FFFF, 32'h0, 1'b1});
    vt.push_back('{1'b0, 3'b010, 32'(4 * DW), 32'h0, 32'h0, 1'b1});
    vt.push_back('{1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1});
    vt.push_back('{1'b1, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1});
    vt.push_back('{1'b1, 3'b000, 32'(4 * DW), 32'hFF, 32'h0, 1'b1});
    vt.push_back('{1'b1, 3'b100, 32'h10, 32'h0, 32'h0, 1'b1});
    vt.push_back('{1'b0, 3'b010, 32'h10, 32'h0, 32'h1234_AAEF, 1'b0});
    vt.push_back('{1'b0, 3'b100, 32'h11, 32'h0, 32'h0000_00AA, 1'b0});
    vt.push_back('{1'b0, 3'b101, 32'h12, 32'h0, 32'h0000_1234, 1'b0});

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_req_ready", 32'(rr2), 32'h0);
    check("rst_rsp_valid", 32'(rv2), 32'h0);
    check("rst_rsp_rdata", rd2, 32'h0);
    check("rst_rsp_err",   32'(re2), 32'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    check("idle_req_ready", 32'(rr2), 32'h1);

    // Table-driven vectors on the LATENCY=2 instance
    for (int i = 0; i < vt.size(); i++) begin
      do_req(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, rd, er, lat);
      check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rdata);
      check($sformatf("vec%0d_err", i), 32'(er), 32'(vt[i].exp_err));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
    end

    // Backpressure: response held 5 cycles, a request pulse meanwhile is ignored
    @(negedge clock);
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_valid = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
    guard = 0;
    @(negedge clock);
    while (!rv2 && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold%0d_valid", i), 32'(rv2), 32'h1);
      check($sformatf("hold%0d_rdata", i), rd2, 32'h1234_AAEF);
      check($sformatf("hold%0d_err", i), 32'(re2), 32'h0);
      check($sformatf("hold%0d_ready", i), 32'(rr2), 32'h0);
      if (i == 2) begin
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'hFFFF_FFFF;
        req_valid = 1'b1;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clock);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clock);
    #1 rsp_ready = 1'b0;
    @(negedge clock);
    check("hs_valid_cleared", 32'(rv2), 32'h0);
    check("hs_rdata_cleared", rd2, 32'h0);
    check("hs_ready_next", 32'(rr2), 32'h1);
    repeat (4) @(negedge clock);
    check("no_phantom_rsp", 32'(rv2), 32'h0);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
    check("pulse_ignored", rd, 32'h1234_AAEF);

    // Reset during WAIT of a store: discarded, outputs clear asynchronously
    @(negedge clock);
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'hCAFE_CAFE;
    req_valid = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    #1 reset_n = 1'b0;
    #1;
    check("wait_rst_ready", 32'(rr2), 32'h0);
    check("wait_rst_valid", 32'(rv2), 32'h0);
    check("wait_rst_rdata", rd2, 32'h0);
    check("wait_rst_err",   32'(re2), 32'h0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    do_req(1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat);
    check("wait_rst_old_value", rd, 32'h0BAD_F00D);

    // Reset during RESP of a store: already committed, response dropped
    @(negedge clock);
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h24; req_wdata = 32'h7777_8888;
    req_valid = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
    guard = 0;
    @(negedge clock);
    while (!rv2 && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    check("resp_before_rst", 32'(rv2), 32'h1);
    #1 reset_n = 1'b0;
    #1;
    check("resp_rst_valid", 32'(rv2), 32'h0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    do_req(1'b0, 3'b010, 32'h24, 32'h0, rd, er, lat);
    check("resp_rst_committed", rd, 32'h7777_8888);

    // LATENCY=0 instance
    sel = 1'b1;
    repeat (2) @(negedge clock);
    do_req(1'b1, 3'b010, 32'h08, 32'h5566_7788, rd, er, lat);
    check("l0_sw_latency", 32'(lat), 32'd1);
    check("l0_sw_err", 32'(er), 32'h0);
    do_req(1'b0, 3'b001, 32'h0A, 32'h0, rd, er, lat);
    check("l0_lh_rdata", rd, 32'h0000_5566);
    check("l0_lh_latency", 32'(lat), 32'd1);
    do_req(1'b0, 3'b000, 32'h08, 32'h0, rd, er, lat);
    check("l0_lb_rdata", rd, 32'hFFFF_FF88);
    do_req(1'b0, 3'b010, 32'h09, 32'h0, rd, er, lat);
    check("l0_lw_mis_err", 32'(er), 32'h1);
    check("l0_lw_mis_rdata", rd, 32'h0);
    check("l0_err_latency", 32'(lat), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
